// File: rtl/mux_cfg_frame_mem_if.sv
// Config-frame bus between a configuration controller (master) and the
// mux select memory bank (slave).
interface mux_cfg_frame_mem_if #(
   parameter int unsigned LEN = 12
);
   logic           cfg_start;
   logic           ccff_en;
   logic           ccff_head;
   logic           ccff_tail;
   logic [LEN-1:0] mem_out;
   logic [LEN-1:0] mem_outb;
   logic           cfg_busy;
   logic           cfg_done;
   logic           cfg_err;

   modport master (
      output cfg_start, ccff_en, ccff_head,
      input  ccff_tail, mem_out, mem_outb, cfg_busy, cfg_done, cfg_err
   );

   modport slave (
      input  cfg_start, ccff_en, ccff_head,
      output ccff_tail, mem_out, mem_outb, cfg_busy, cfg_done, cfg_err
   );
endinterface

// File: rtl/mux_cfg_frame_mem.sv
// Serial config frame receiver: shifts NUM_MEM*MEM_SIZE bits plus even parity,
// then atomically commits them to the mux select outputs.
module mux_cfg_frame_mem #(
   parameter int unsigned NUM_MEM  = 4,
   parameter int unsigned MEM_SIZE = 3
) (
   input  logic                 prog_clk,
   input  logic                 prog_reset_n,
   mux_cfg_frame_mem_if.slave   bus
);
   localparam int unsigned LEN   = NUM_MEM * MEM_SIZE;
   localparam int unsigned CNT_W = $clog2(LEN + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

   state_e             state_q, state_d;
   logic [LEN-1:0]     shreg_q, shreg_d;
   logic [LEN-1:0]     mem_q,   mem_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               parity_q, parity_d;
   logic               done_q,  done_d;
   logic               err_q,   err_d;
   logic               busy_q,  busy_d;

   // Next-state and datapath decisions
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      mem_d    = mem_q;
      cnt_d    = cnt_q;
      parity_d = parity_q;
      done_d   = 1'b0;
      err_d    = err_q;

      unique case (state_q)
         IDLE: begin
            if (bus.cfg_start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         SHIFT: begin
            // A restart wins over everything; a bit qualified alongside it opens the new frame
            if (bus.cfg_start) begin
               cnt_d = '0;
               err_d = 1'b0;
               if (bus.ccff_en) begin
                  shreg_d = {shreg_q[LEN-2:0], bus.ccff_head};
                  cnt_d   = CNT_W'(1);
               end
            end else if (bus.ccff_en) begin
               if (cnt_q == CNT_W'(LEN)) begin
                  parity_d = bus.ccff_head;
                  state_d  = CHECK;
               end else begin
                  shreg_d = {shreg_q[LEN-2:0], bus.ccff_head};
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (((^shreg_q) ^ parity_q) == 1'b0) begin
               mem_d  = shreg_q;
               done_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge prog_clk) begin
      if (!prog_reset_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         mem_q    <= '0;
         cnt_q    <= '0;
         parity_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         mem_q    <= mem_d;
         cnt_q    <= cnt_d;
         parity_q <= parity_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.ccff_tail = shreg_q[LEN-1];
   assign bus.mem_out   = mem_q;
   assign bus.mem_outb  = ~mem_q;
   assign bus.cfg_busy  = busy_q;
   assign bus.cfg_done  = done_q;
   assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_mux_cfg_frame_mem.sv
// Self-checking bench for mux_cfg_frame_mem: directed scenarios plus random
// frames against a bit-history model of the serial config chain.
module tb_mux_cfg_frame_mem;
   localparam int unsigned LEN = 12;

   logic prog_clk;
   logic prog_reset_n;

   mux_cfg_frame_mem_if #(.LEN(LEN)) bus ();

   mux_cfg_frame_mem #(.NUM_MEM(4), .MEM_SIZE(3)) dut (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .bus          (bus)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: expected committed word and every bit shifted since reset
   logic [LEN-1:0] exp_mem = '0;
   logic           hist[$];

   function automatic logic exp_tail();
      if (hist.size() < LEN) return 1'b0;
      return hist[hist.size() - LEN];
   endfunction

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic gap_cycle();
      bus.ccff_en   = 1'b0;
      bus.ccff_head = 1'($urandom);
      tick();
      n_cmp++;
      if (bus.ccff_tail !== exp_tail()) begin
         n_err++;
         $display("FAIL gap_tail: got %b expected %b", bus.ccff_tail, exp_tail());
      end
   endtask

   task automatic shift_bit(input logic b, input int gaps);
      repeat (gaps) gap_cycle();
      bus.ccff_en   = 1'b1;
      bus.ccff_head = b;
      tick();
      bus.ccff_en = 1'b0;
      hist.push_back(b);
      n_cmp++;
      if (bus.ccff_tail !== exp_tail()) begin
         n_err++;
         $display("FAIL shift_tail: got %b expected %b", bus.ccff_tail, exp_tail());
      end
      n_cmp++;
      if (bus.mem_out !== exp_mem || bus.cfg_done !== 1'b0 || bus.cfg_busy !== 1'b1) begin
         n_err++;
         $display("FAIL shift_hold: mem_out=%h done=%b busy=%b expected mem_out=%h done=0 busy=1",
                  bus.mem_out, bus.cfg_done, bus.cfg_busy, exp_mem);
      end
   endtask

   task automatic start_frame();
      bus.cfg_start = 1'b1;
      bus.ccff_en   = 1'b0;
      tick();
      bus.cfg_start = 1'b0;
      n_cmp++;
      if (bus.cfg_busy !== 1'b1 || bus.cfg_err !== 1'b0) begin
         n_err++;
         $display("FAIL start: busy=%b err=%b expected busy=1 err=0", bus.cfg_busy, bus.cfg_err);
      end
   endtask

   task automatic finish_frame(input logic [LEN-1:0] d, input logic p, input int gaps,
                               input logic start_in_check);
      logic ok;
      ok = ((($countones(d) + int'(p)) % 2) == 0);
      repeat (gaps) gap_cycle();
      bus.ccff_en   = 1'b1;
      bus.ccff_head = p;
      tick();
      bus.ccff_en = 1'b0;
      n_cmp++;
      if (bus.cfg_busy !== 1'b1 || bus.cfg_done !== 1'b0 || bus.mem_out !== exp_mem) begin
         n_err++;
         $display("FAIL check_cycle: busy=%b done=%b mem_out=%h expected busy=1 done=0 mem_out=%h",
                  bus.cfg_busy, bus.cfg_done, bus.mem_out, exp_mem);
      end
      bus.cfg_start = start_in_check;
      tick();
      bus.cfg_start = 1'b0;
      if (ok) exp_mem = d;
      n_cmp++;
      if (bus.mem_out !== exp_mem || bus.mem_outb !== ~exp_mem) begin
         n_err++;
         $display("FAIL commit_data: mem_out=%h mem_outb=%h expected %h / %h",
                  bus.mem_out, bus.mem_outb, exp_mem, ~exp_mem);
      end
      n_cmp++;
      if (bus.cfg_done !== ok || bus.cfg_err !== !ok || bus.cfg_busy !== 1'b0) begin
         n_err++;
         $display("FAIL commit_flags: done=%b err=%b busy=%b expected done=%b err=%b busy=0",
                  bus.cfg_done, bus.cfg_err, bus.cfg_busy, ok, !ok);
      end
      tick();
      n_cmp++;
      if (bus.cfg_done !== 1'b0 || bus.cfg_err !== !ok || bus.mem_out !== exp_mem) begin
         n_err++;
         $display("FAIL after_commit: done=%b err=%b mem_out=%h expected done=0 err=%b mem_out=%h",
                  bus.cfg_done, bus.cfg_err, bus.mem_out, !ok, exp_mem);
      end
   endtask

   task automatic send_frame(input logic [LEN-1:0] d, input logic p, input int gapmode,
                             input logic start_in_check);
      start_frame();
      for (int i = LEN - 1; i >= 0; i--)
         shift_bit(d[i], (gapmode == 2) ? $urandom_range(0, 2) : gapmode);
      finish_frame(d, p, (gapmode == 2) ? $urandom_range(0, 2) : gapmode, start_in_check);
   endtask

   task automatic test_reset();
      prog_reset_n = 1'b0;
      repeat (2) begin
         bus.cfg_start = 1'($urandom);
         bus.ccff_en   = 1'($urandom);
         bus.ccff_head = 1'($urandom);
         tick();
      end
      n_cmp++;
      if (bus.mem_out !== 12'h000 || bus.mem_outb !== 12'hFFF) begin
         n_err++;
         $display("FAIL reset_mem: mem_out=%h mem_outb=%h expected 000 / fff", bus.mem_out, bus.mem_outb);
      end
      n_cmp++;
      if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0 || bus.cfg_busy !== 1'b0 || bus.ccff_tail !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags: done=%b err=%b busy=%b tail=%b expected all 0",
                  bus.cfg_done, bus.cfg_err, bus.cfg_busy, bus.ccff_tail);
      end
      bus.cfg_start = 1'b0;
      bus.ccff_en   = 1'b0;
      prog_reset_n  = 1'b1;
      hist.delete();
      exp_mem = '0;
      tick();
   endtask

   task automatic test_good_frame();
      send_frame(12'hA5C, 1'b0, 0, 1'b0);
   endtask

   task automatic test_bad_parity();
      send_frame(12'h3F0, 1'b1, 0, 1'b0);
      n_cmp++;
      if (bus.mem_out !== 12'hA5C) begin
         n_err++;
         $display("FAIL bad_parity_keep: mem_out=%h expected a5c", bus.mem_out);
      end
      start_frame();
      n_cmp++;
      if (bus.cfg_err !== 1'b0) begin
         n_err++;
         $display("FAIL err_clear: err=%b expected 0", bus.cfg_err);
      end
   endtask

   task automatic test_gapped();
      send_frame(12'h001, 1'b1, 1, 1'b0);
   endtask

   task automatic test_abort();
      logic [LEN-1:0] d;
      start_frame();
      for (int i = 0; i < 7; i++) shift_bit(1'($urandom), 0);
      // Restart with a qualified bit: it becomes the MSB of the new frame
      bus.cfg_start = 1'b1;
      bus.ccff_en   = 1'b1;
      bus.ccff_head = 1'b1;
      tick();
      bus.cfg_start = 1'b0;
      bus.ccff_en   = 1'b0;
      hist.push_back(1'b1);
      n_cmp++;
      if (bus.cfg_busy !== 1'b1 || bus.ccff_tail !== exp_tail() || bus.cfg_done !== 1'b0) begin
         n_err++;
         $display("FAIL abort_restart: busy=%b tail=%b done=%b expected busy=1 tail=%b done=0",
                  bus.cfg_busy, bus.ccff_tail, bus.cfg_done, exp_tail());
      end
      d = 12'hFFF;
      for (int i = LEN - 2; i >= 0; i--) shift_bit(d[i], 0);
      finish_frame(d, 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_frame();
      start_frame();
      for (int i = 0; i < 5; i++) shift_bit(1'($urandom), 0);
      prog_reset_n  = 1'b0;
      bus.ccff_en   = 1'($urandom);
      bus.ccff_head = 1'($urandom);
      tick();
      prog_reset_n = 1'b1;
      exp_mem = '0;
      hist.delete();
      n_cmp++;
      if (bus.mem_out !== 12'h000 || bus.mem_outb !== 12'hFFF || bus.cfg_busy !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: mem_out=%h mem_outb=%h busy=%b expected 000 / fff / 0",
                  bus.mem_out, bus.mem_outb, bus.cfg_busy);
      end
      for (int i = 0; i < 4; i++) begin
         bus.ccff_en   = 1'b1;
         bus.ccff_head = 1'b1;
         tick();
         n_cmp++;
         if (bus.cfg_busy !== 1'b0 || bus.ccff_tail !== 1'b0 || bus.mem_out !== 12'h000 || bus.cfg_done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignore: busy=%b tail=%b mem_out=%h done=%b expected 0/0/000/0",
                     bus.cfg_busy, bus.ccff_tail, bus.mem_out, bus.cfg_done);
         end
      end
      bus.ccff_en = 1'b0;
      tick();
   endtask

   task automatic test_random_frames();
      logic [LEN-1:0] d;
      logic           p;
      for (int n = 0; n < 30; n++) begin
         d = LEN'($urandom);
         p = 1'($urandom);
         send_frame(d, p, $urandom_range(0, 2), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      logic [LEN-1:0] d;
      for (int n = 0; n < 6; n++) begin
         d = LEN'($urandom);
         send_frame(d, 1'($countones(d) & 1), 0, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      prog_reset_n  = 1'b0;
      bus.cfg_start = 1'b0;
      bus.ccff_en   = 1'b0;
      bus.ccff_head = 1'b0;
      test_reset();
      test_good_frame();
      test_bad_parity();
      test_gapped();
      test_abort();
      test_reset_mid_frame();
      test_random_frames();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mux_cfg_frame_mem.md
Name: mux_cfg_frame_mem

Overview:
- Configuration memory bank that drives the `sram`/`sram_inv` select inputs of a group of routing mux trees. Sits directly upstream of those muxes.
- Receives a serial config frame: NUM_MEM × MEM_SIZE data bits plus one even-parity bit.
- Checks parity, then commits the frame atomically to shadow outputs. Mux selects never see partially shifted data.
- Also passes the shift register MSB out for daisy-chain readback.

Parameters:
- NUM_MEM, 4, number of mux trees served
- MEM_SIZE, 3, select bits per mux tree (matches a 5-input tapbuf mux)
- LEN, NUM_MEM*MEM_SIZE (derived, not overridable), total data bits per frame

Ports:
- prog_clk  input  1  configuration clock; all logic is on its rising edge
- prog_reset_n  input  1  synchronous active-low reset
- cfg_start  input  1  one-cycle pulse; opens a new frame
- ccff_en  input  1  qualifies ccff_head; one bit is shifted per cycle with ccff_en=1
- ccff_head  input  1  serial config data, MSB first
- ccff_tail  output  1  shift register bit LEN-1, for readback/daisy chain
- mem_out  output  LEN  committed select bits; mux k uses bits [k*MEM_SIZE +: MEM_SIZE]
- mem_outb  output  LEN  bitwise complement of mem_out, at all times
- cfg_busy  output  1  high in SHIFT or CHECK
- cfg_done  output  1  one-cycle pulse on successful commit
- cfg_err  output  1  sticky parity error flag

Behaviour:
- Clock and reset: one clock, prog_clk. Reset is synchronous and active-low: sampled only on the rising edge of prog_clk when prog_reset_n=0.
- Reset values: state=IDLE, shreg=0, bit counter=0, mem_out=0, mem_outb=all ones, cfg_done=0, cfg_err=0, cfg_busy=0, ccff_tail=0.
- Reset has priority over every other input. Reset mid-frame discards the frame and clears mem_out.
- Shift register update (every edge with ccff_en=1 in SHIFT): shreg <= {shreg[LEN-2:0], ccff_head}. ccff_tail = shreg[LEN-1].
- Bit counter is $clog2(LEN+1) bits wide and counts data bits accepted in the current frame.
- States:
  - IDLE: cfg_start=1 → SHIFT; counter cleared, cfg_err cleared. ccff_en is ignored in IDLE.
  - SHIFT:
    - While counter<LEN, ccff_en=1 shifts one data bit and increments the counter.
    - When counter==LEN, the next ccff_en=1 cycle captures ccff_head as the parity bit (it is not shifted) → CHECK.
    - ccff_en=0 holds state and data.
  - CHECK (exactly 1 cycle):
    - If (^shreg) ^ parity == 0: mem_out <= shreg, cfg_done=1 for that edge's following cycle, → IDLE.
    - Otherwise: cfg_err <= 1, mem_out unchanged, → IDLE.
- Latency: parity bit sampled at edge N. CHECK occupies cycle N→N+1. mem_out and cfg_done are visible after edge N+1. cfg_done drops after edge N+2.
- cfg_start in SHIFT aborts the frame: counter cleared, stays in SHIFT, cfg_err cleared. If ccff_en=1 in the same cycle, that bit is shifted as bit 0 of the new frame (counter=1).
- cfg_start in CHECK is ignored; the check completes.
- cfg_busy = (state==SHIFT or state==CHECK).
- mem_out changes only at commit or reset: no glitches or partial updates reach the mux selects.
- mem_outb is driven as ~mem_out combinationally from the same register; there is no separate flop.
- cfg_err stays high until the next cfg_start or reset.

Test Plan:
- Reset: hold prog_reset_n=0 for 2 edges with random inputs → mem_out=0x000, mem_outb=0xFFF, cfg_done=0, cfg_err=0, cfg_busy=0.
- Good frame: cfg_start, then 12 bits of 0xA5C MSB first (six ones) plus parity bit 0, ccff_en=1 continuously → cfg_busy high through CHECK. One edge after the parity bit: mem_out=0xA5C, mem_outb=0x5A3, cfg_done pulses exactly 1 cycle.
- Bad parity: starting with mem_out=0xA5C, send frame 0x3F0 with parity 1 → cfg_err=1, cfg_done stays 0, mem_out stays 0xA5C. A following cfg_start clears cfg_err.
- Gapped shifting: send frame 0x001 with parity 1, ccff_en toggling 1/0 every cycle → commit occurs after the 13th qualified bit. mem_out=0x001. ccff_tail equals shreg[11] at each step.
- Abort: cfg_start mid-frame after 7 bits, then full frame 0xFFF with parity 0 → mem_out=0xFFF. No commit from the aborted partial frame.
- Reset mid-frame: after 5 bits, assert prog_reset_n=0 for one edge → state IDLE, mem_out=0x000. A subsequent ccff_en=1 without cfg_start has no effect.
